// File: rtl/window_threshold_detector_pkg.sv
// Shared constants and width rule for the sliding-window threshold detector.
// Holds the default window/threshold values and the count-width helper.
package window_threshold_detector_pkg;

   localparam int unsigned DEF_DEPTH  = 3;
   localparam int unsigned DEF_THRESH = 2;

   // Bits needed to hold a ones-count from 0 up to and including depth
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/window_threshold_detector_window_shift_reg.sv
// Enable/clear shift register holding the last p_depth samples.
// Bit 0 is the newest sample; oldest_o is the bit that leaves on the next shift.
module window_shift_reg #(
   parameter int unsigned p_depth = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic               bit_i,
   output logic [p_depth-1:0] window_o,
   output logic               oldest_o
);

   logic [p_depth-1:0] window_q;
   logic [p_depth-1:0] window_d;

   // Truncating cast drops the oldest bit and needs no special case for p_depth=1
   always_comb begin
      window_d = window_q;
      if (clr_i) begin
         window_d = '0;
      end else if (en_i) begin
         window_d = p_depth'({window_q, bit_i});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         window_q <= '0;
      end else begin
         window_q <= window_d;
      end
   end

   assign window_o = window_q;
   assign oldest_o = window_q[p_depth-1];

endmodule

// File: rtl/window_threshold_detector.sv
// Sliding-window threshold detector: flags when >= p_thresh of the last p_depth samples are 1.
// Optional sticky detect flag on output seen is enabled by defining WINDOW_DET_STICKY_EN.
module window_threshold_detector
   import window_threshold_detector_pkg::*;
#(
   parameter int unsigned p_depth  = DEF_DEPTH,
   parameter int unsigned p_thresh = DEF_THRESH,
   localparam int unsigned CW      = cnt_width(p_depth)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_val,
   input  logic          in_bit,
   input  logic          clear,
   output logic          out_val,
   output logic          out,
   output logic [CW-1:0] count,
   output logic          seen
);

   if (p_depth < 1 || p_thresh < 1 || p_thresh > p_depth) begin : g_param_check
      $error("window_threshold_detector: need p_depth>=1 and 1<=p_thresh<=p_depth");
   end

   logic [p_depth-1:0] window_w;
   logic               oldest_w;
   logic [CW-1:0]      fill_q, fill_d;
   logic [CW-1:0]      count_q, count_d;
   logic               out_val_q, out_val_d;
   logic               out_q, out_d;

   window_shift_reg #(.p_depth(p_depth)) u_window (
      .clk      (clk),
      .rst      (rst),
      .en_i     (in_val),
      .clr_i    (clear),
      .bit_i    (in_bit),
      .window_o (window_w),
      .oldest_o (oldest_w)
   );

   // The leaving bit is still a reset zero until the window has filled, so no fill gating is needed
   always_comb begin
      fill_d  = fill_q;
      count_d = count_q;
      if (clear) begin
         fill_d  = '0;
         count_d = '0;
      end else if (in_val) begin
         if (fill_q != CW'(p_depth)) begin
            fill_d = CW'(fill_q + CW'(1));
         end
         count_d = CW'(count_q + CW'(in_bit) - CW'(oldest_w));
      end
      out_val_d = (fill_d == CW'(p_depth));
      out_d     = out_val_d && (count_d >= CW'(p_thresh));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q    <= '0;
         count_q   <= '0;
         out_val_q <= 1'b0;
         out_q     <= 1'b0;
      end else begin
         fill_q    <= fill_d;
         count_q   <= count_d;
         out_val_q <= out_val_d;
         out_q     <= out_d;
      end
   end

   // Incremental count must always equal a popcount of the stored window
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ($countones(window_w) == int'(count_q))
            else $error("window_threshold_detector: count diverged from window popcount");
      end
   end

`ifdef WINDOW_DET_STICKY_EN
   logic seen_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         seen_q <= 1'b0;
      end else if (out_d) begin
         seen_q <= 1'b1;
      end
   end

   assign seen = seen_q;
`else
   assign seen = 1'b0;
`endif

   assign out_val = out_val_q;
   assign out     = out_q;
   assign count   = count_q;

endmodule

// File: tb/tb_window_threshold_detector.sv
// Scoreboard bench for window_threshold_detector: default (3,2) and (8,5) instances share stimulus.
// Expected results come from a queue-based window model; a negedge monitor pops and compares.
module tb_window_threshold_detector;

   localparam int unsigned DA = 3;
   localparam int unsigned TA = 2;
   localparam int unsigned DB = 8;
   localparam int unsigned TB = 5;

   logic       clk;
   logic       rst;
   logic       in_val;
   logic       in_bit;
   logic       clear;
   logic       out_val_a, out_a, seen_a;
   logic [1:0] count_a;
   logic       out_val_b, out_b, seen_b;
   logic [3:0] count_b;

   window_threshold_detector #(.p_depth(DA), .p_thresh(TA)) dut_a (
      .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .clear(clear),
      .out_val(out_val_a), .out(out_a), .count(count_a), .seen(seen_a)
   );

   window_threshold_detector #(.p_depth(DB), .p_thresh(TB)) dut_b (
      .clk(clk), .rst(rst), .in_val(in_val), .in_bit(in_bit), .clear(clear),
      .out_val(out_val_b), .out(out_b), .count(count_b), .seen(seen_b)
   );

   typedef struct {
      int cnt_a; bit ov_a; bit o_a; bit s_a;
      int cnt_b; bit ov_b; bit o_b; bit s_b;
   } exp_t;

   exp_t sb[$];
   bit   hist_a[$];
   bit   hist_b[$];
   bit   sticky_a, sticky_b;
   int   tests = 0;
   int   fails = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int popc(input bit q[$]);
      int n = 0;
      foreach (q[i]) n += int'(q[i]);
      return n;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus; the model's view after that edge goes to the scoreboard
   task automatic step(input bit r, input bit v, input bit b, input bit c);
      exp_t e;
      rst = r; in_val = v; in_bit = b; clear = c;
      @(posedge clk);
      #1;
      if (r || c) begin
         hist_a.delete(); hist_b.delete();
         sticky_a = 1'b0; sticky_b = 1'b0;
      end else if (v) begin
         hist_a.push_back(b); hist_b.push_back(b);
         if (hist_a.size() > DA) void'(hist_a.pop_front());
         if (hist_b.size() > DB) void'(hist_b.pop_front());
      end
      e.cnt_a = popc(hist_a);
      e.ov_a  = (hist_a.size() == DA);
      e.o_a   = e.ov_a && (e.cnt_a >= TA);
      e.cnt_b = popc(hist_b);
      e.ov_b  = (hist_b.size() == DB);
      e.o_b   = e.ov_b && (e.cnt_b >= TB);
`ifdef WINDOW_DET_STICKY_EN
      if (e.o_a) sticky_a = 1'b1;
      if (e.o_b) sticky_b = 1'b1;
`endif
      e.s_a = sticky_a;
      e.s_b = sticky_b;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("count_a",   int'(count_a),   e.cnt_a);
         chk("out_val_a", int'(out_val_a), int'(e.ov_a));
         chk("out_a",     int'(out_a),     int'(e.o_a));
         chk("seen_a",    int'(seen_a),    int'(e.s_a));
         chk("count_b",   int'(count_b),   e.cnt_b);
         chk("out_val_b", int'(out_val_b), int'(e.ov_b));
         chk("out_b",     int'(out_b),     int'(e.o_b));
         chk("seen_b",    int'(seen_b),    int'(e.s_b));
      end
   end

   initial begin
      bit [2:0] pat;
      bit [4:0] stream;
      int       guard;
      rst = 1'b1; in_val = 1'b0; in_bit = 1'b0; clear = 1'b0;
      sticky_a = 1'b0; sticky_b = 1'b0;

      // Reset held two cycles, then three idle cycles
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (3) step(0, 0, 1, 0);

      // All eight 3-bit patterns from an empty window
      for (int p = 0; p < 8; p++) begin
         pat = 3'(p);
         step(0, 0, 0, 1);
         for (int i = 2; i >= 0; i--) step(0, 1, pat[i], 0);
         step(0, 0, 0, 0);
      end

      // Continuous stream 1,1,0,0,1
      step(0, 0, 0, 1);
      stream = 5'b10011;
      for (int i = 0; i < 5; i++) step(0, 1, stream[i], 0);

      // Clear wins over a same-cycle sample
      step(0, 0, 0, 1);
      step(0, 1, 1, 0);
      step(0, 1, 1, 0);
      step(0, 1, 1, 1);
      step(0, 0, 0, 0);

      // Detect, then zeros, then clear drops the sticky flag
      for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);

      // Random stream with gaps, rare clears and mid-stream resets
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      end
      step(0, 0, 0, 0);

      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (sb.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d scoreboard entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
